// File: rtl/divu_p6y3.sv
// rtl/divu_p6y3.sv - restoring shift-subtract unsigned divider, one quotient bit per clock
module divu_p6y3 #(
    parameter int P_WIDTH = 6,
    parameter int Y_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [P_WIDTH-1:0] p,
    input  logic [Y_WIDTH-1:0] y,
    output logic [P_WIDTH-1:0] q,
    output logic [Y_WIDTH-1:0] r,
    output logic               dbz,
    output logic               busy,
    output logic               rdy
);
    localparam int C_WIDTH = $clog2(P_WIDTH);
    localparam logic [C_WIDTH-1:0] C_LAST = C_WIDTH'(P_WIDTH - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [P_WIDTH-1:0] dvd;
    logic [Y_WIDTH:0]   rem;
    logic [P_WIDTH-1:0] quo;
    logic [Y_WIDTH-1:0] dvs;
    logic [C_WIDTH-1:0] cnt;

    logic [Y_WIDTH:0]   rem_sh;
    logic [Y_WIDTH:0]   rem_nx;
    logic [P_WIDTH-1:0] quo_nx;
    logic               take;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = (rem << 1) | {{Y_WIDTH{1'b0}}, dvd[P_WIDTH-1]};
        take   = rem_sh >= {1'b0, dvs};
        rem_nx = take ? (rem_sh - {1'b0, dvs}) : rem_sh;
        quo_nx = (quo << 1) | {{(P_WIDTH-1){1'b0}}, take};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dvd   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (y == '0) begin
                            q   <= '1;
                            r   <= '0;
                            dbz <= 1'b1;
                        end else begin
                            dvd   <= p;
                            dvs   <= y;
                            rem   <= '0;
                            quo   <= '0;
                            cnt   <= C_LAST;
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    dvd <= dvd << 1;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    // Results are published only here, so q/r/dbz hold through RUN.
                    if (cnt == '0) begin
                        q     <= quo_nx;
                        r     <= rem_nx[Y_WIDTH-1:0];
                        dbz   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign rdy  = ~busy;
endmodule

// File: tb/tb_divu_p6y3.sv
// tb/tb_divu_p6y3.sv - self-checking bench for divu_p6y3 with a behavioural model
module tb_divu_p6y3;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] p = '0;
    logic [2:0] y = '0;
    logic [5:0] q;
    logic [2:0] r;
    logic       dbz, busy, rdy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m_busy = 0, m_left = 0, m_q = 0, m_r = 0, m_dbz = 0, m_pq = 0, m_pr = 0;

    divu_p6y3 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p(p), .y(y),
        .q(q), .r(r), .dbz(dbz), .busy(busy), .rdy(rdy)
    );

    always #5 clk = ~clk;

    // Model: what each output must be after every edge, from the arithmetic definition.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_q = 0; m_r = 0; m_dbz = 0;
        end else if (m_busy == 0) begin
            if (start) begin
                if (y == 0) begin
                    m_q = 63; m_r = 0; m_dbz = 1;
                end else begin
                    m_busy = 1; m_left = 6;
                    m_pq = int'(p) / int'(y);
                    m_pr = int'(p) % int'(y);
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0; m_q = m_pq; m_r = m_pr; m_dbz = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", int'(busy), m_busy);
            chk("model_rdy", int'(rdy), 1 - m_busy);
            chk("model_q", int'(q), m_q);
            chk("model_r", int'(r), m_r);
            chk("model_dbz", int'(dbz), m_dbz);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        if (busy) chk("timeout", 1, 0);
    endtask

    task automatic do_op(input logic [5:0] pp, input logic [2:0] yy);
        int n;
        p = pp; y = yy; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
    endtask

    initial begin
        int n;
        repeat (2) step();
        chk_en = 1'b1;
        chk("reset_q", int'(q), 0);
        chk("reset_r", int'(r), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rdy", int'(rdy), 1);
        rst_n = 1'b1;
        step();

        // 45/6 with busy duration
        p = 6'd45; y = 3'd6; start = 1'b1;
        step();
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        wait_done(n);
        chk("busy_cycles", n, 6);
        chk("q_45_6", int'(q), 7);
        chk("r_45_6", int'(r), 3);
        chk("dbz_45_6", int'(dbz), 0);
        repeat (3) step();
        chk("hold_q", int'(q), 7);
        chk("hold_r", int'(r), 3);

        // Back-to-back with start held high
        p = 6'd63; y = 3'd7; start = 1'b1;
        step();
        p = 6'd5; y = 3'd7;
        wait_done(n);
        chk("b2b_cycles1", n, 6);
        chk("q_63_7", int'(q), 9);
        chk("r_63_7", int'(r), 0);
        step();
        chk("b2b_accept2", int'(busy), 1);
        p = 6'd0; y = 3'd1;
        wait_done(n);
        chk("q_5_7", int'(q), 0);
        chk("r_5_7", int'(r), 5);
        step();
        chk("b2b_accept3", int'(busy), 1);
        start = 1'b0;
        wait_done(n);
        chk("q_0_1", int'(q), 0);
        chk("r_0_1", int'(r), 0);

        // Divide by zero then recovery
        p = 6'd20; y = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("dbz_busy", int'(busy), 0);
        chk("dbz_q", int'(q), 63);
        chk("dbz_r", int'(r), 0);
        chk("dbz_flag", int'(dbz), 1);
        do_op(6'd20, 3'd3);
        chk("q_20_3", int'(q), 6);
        chk("r_20_3", int'(r), 2);
        chk("dbz_20_3", int'(dbz), 0);

        // Start while busy is ignored
        p = 6'd45; y = 3'd6; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        p = 6'd10; y = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        chk("ign_q", int'(q), 7);
        chk("ign_r", int'(r), 3);
        step();
        chk("ign_not_queued", int'(busy), 0);

        // Reset mid-run
        p = 6'd60; y = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(rdy), 1);
        do_op(6'd60, 3'd7);
        chk("q_60_7", int'(q), 8);
        chk("r_60_7", int'(r), 4);

        // Exhaustive sweep
        for (int pi = 0; pi < 64; pi++) begin
            for (int yi = 0; yi < 8; yi++) begin
                do_op(6'(pi), 3'(yi));
                if (yi == 0) begin
                    chk("ex_dbz", int'(dbz), 1);
                    chk("ex_dbz_q", int'(q), 63);
                end else begin
                    chk("ex_recon", int'(q) * yi + int'(r), pi);
                    chk("ex_r_lt_y", int'(int'(r) < yi), 1);
                    chk("ex_q", int'(q), pi / yi);
                end
            end
        end

        // Random traffic including held start and occasional reset
        for (int i = 0; i < 3000; i++) begin
            start = 1'($urandom_range(0, 1));
            p = 6'($urandom);
            y = 3'($urandom);
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
